calc_sequencer: RTL and testbench

Top-level calculator controller for the button/display datapath. It collects keypad codes into a packed operand/operator word and starts the two's-complement conversion stage. It waits for the conversion stage's finish flag, then runs the arithmetic unit and holds its result for the display. A timeout watchdog guards every downstream handshake.

---
 rtl/calc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Calculator controller. It collects keypad codes into a packed
//   operand/operator word, starts the conversion stage and then the
//   arithmetic unit, and holds the result for the display. A watchdog
//   bounds the wait on each downstream handshake.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   key_valid/key_code  one-cycle key strobe and 4-bit code
//   complement1_finish  conversion stage done (level)
//   alu_done/alu_result arithmetic unit done (level) and its result
//   nr_coded            {first operand, second operand, operator}
//   complement1_sel     start pulse to the conversion stage
//   alu_start           start pulse to the arithmetic unit
//   result/result_valid latched result for the display
//   busy                conversion or arithmetic in progress
//   error               timeout or invalid key sequence
//
// state    | meaning
// ---------+------------------------------------------
// A_ENTRY  | accepting the first operand
// OP_ENTRY | first operand held, waiting for an operator
// B_ENTRY  | accepting the second operand
// CONV     | conversion stage running
// EXEC     | arithmetic unit running
// SHOW     | result displayed
// ERR      | error latched, only a clear key leaves
module calc_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        complement1_finish,
    input  logic        alu_done,
    input  logic [7:0]  alu_result,
    output logic [11:0] nr_coded,
    output logic        complement1_sel,
    output logic        alu_start,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        A_ENTRY,
        OP_ENTRY,
        B_ENTRY,
        CONV,
        EXEC,
        SHOW,
        ERR
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [11:0] nr_d;
    logic [7:0]  result_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        b_seen_q, b_seen_d;
    logic        sel_d;
    logic        start_d;

    logic key_digit;
    logic key_op;
    logic key_eq;
    logic key_clr;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_op    = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
    assign key_eq    = key_valid && (key_code == 4'hE);
    assign key_clr   = key_valid && (key_code == 4'hF);

    // Status outputs decode the state register only, so they carry no
    // combinational path from any input.
    assign busy         = (state_q == CONV) || (state_q == EXEC);
    assign error        = (state_q == ERR);
    assign result_valid = (state_q == SHOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= A_ENTRY;
            nr_coded        <= 12'h000;
            result          <= 8'h00;
            wdog_q          <= 8'h00;
            b_seen_q        <= 1'b0;
            complement1_sel <= 1'b0;
            alu_start       <= 1'b0;
        end else begin
            state_q         <= state_d;
            nr_coded        <= nr_d;
            result          <= result_d;
            wdog_q          <= wdog_d;
            b_seen_q        <= b_seen_d;
            complement1_sel <= sel_d;
            alu_start       <= start_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nr_d     = nr_coded;
        result_d = result;
        wdog_d   = wdog_q;
        b_seen_d = b_seen_q;
        sel_d    = 1'b0;
        start_d  = 1'b0;

        if (key_clr) begin
            // Clear beats everything, including a finish/done arriving
            // in the same cycle; it also aborts any running operation.
            state_d  = A_ENTRY;
            nr_d     = 12'h000;
            result_d = 8'h00;
            wdog_d   = 8'h00;
            b_seen_d = 1'b0;
        end else begin
            case (state_q)
                A_ENTRY: begin
                    if (key_digit) begin
                        nr_d[11:8] = key_code;
                        state_d    = OP_ENTRY;
                    end
                end
                OP_ENTRY: begin
                    if (key_digit) begin
                        nr_d[11:8] = key_code;
                    end else if (key_op) begin
                        nr_d[3:0] = key_code;
                        b_seen_d  = 1'b0;
                        state_d   = B_ENTRY;
                    end else if (key_eq) begin
                        state_d = ERR;
                    end
                end
                B_ENTRY: begin
                    if (key_digit) begin
                        nr_d[7:4] = key_code;
                        b_seen_d  = 1'b1;
                    end else if (key_op) begin
                        nr_d[3:0] = key_code;
                    end else if (key_eq) begin
                        if (b_seen_q) begin
                            state_d = CONV;
                            sel_d   = 1'b1;
                            wdog_d  = 8'h00;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
                CONV: begin
                    // The finish flag is not trusted while our own start
                    // pulse is still on the wire.
                    if (complement1_finish && !complement1_sel) begin
                        state_d = EXEC;
                        start_d = 1'b1;
                        wdog_d  = 8'h00;
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d = ERR;
                    end else begin
                        wdog_d = wdog_q + 8'h01;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        result_d = alu_result;
                        state_d  = SHOW;
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d = ERR;
                    end else begin
                        wdog_d = wdog_q + 8'h01;
                    end
                end
                SHOW: begin
                    if (key_digit) begin
                        nr_d    = {key_code, 8'h00};
                        state_d = OP_ENTRY;
                    end
                end
                ERR: begin
                end
                default: begin
                    state_d = A_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        complement1_finish = 1'b0;
    logic        alu_done = 1'b0;
    logic [7:0]  alu_result = 8'h00;
    logic [11:0] nr_coded;
    logic        complement1_sel;
    logic        alu_start;
    logic [7:0]  result;
    logic        result_valid;
    logic        busy;
    logic        error;

    calc_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk                (clk),
        .rst                (rst),
        .key_valid          (key_valid),
        .key_code           (key_code),
        .complement1_finish (complement1_finish),
        .alu_done           (alu_done),
        .alu_result         (alu_result),
        .nr_coded           (nr_coded),
        .complement1_sel    (complement1_sel),
        .alu_start          (alu_start),
        .result             (result),
        .result_valid       (result_valid),
        .busy               (busy),
        .error              (error)
    );

    always #5 clk = ~clk;

    localparam int TO = 15;

    // Reference model: calculator-level view of what the user has entered.
    localparam int P_FIRST  = 0;
    localparam int P_OPWAIT = 1;
    localparam int P_SECOND = 2;
    localparam int P_BUSY   = 3;
    localparam int P_SHOW   = 4;
    localparam int P_ERR    = 5;

    int         m_phase = P_FIRST;
    logic [3:0] m_a = 0, m_b = 0, m_op = 0;
    bit         m_bseen = 0;
    logic [7:0] m_res = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_sel, input bit exp_start);
        check({tag, ".nr"},    32'(nr_coded),        32'({m_a, m_b, m_op}));
        check({tag, ".res"},   32'(result),          32'(m_res));
        check({tag, ".valid"}, 32'(result_valid),    32'(m_phase == P_SHOW));
        check({tag, ".err"},   32'(error),           32'(m_phase == P_ERR));
        check({tag, ".busy"},  32'(busy),            32'(m_phase == P_BUSY));
        check({tag, ".sel"},   32'(complement1_sel), 32'(exp_sel));
        check({tag, ".start"}, 32'(alu_start),       32'(exp_start));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        key_valid          = 1'b0;
        key_code           = 4'h0;
        complement1_finish = 1'b0;
        alu_done           = 1'b0;
    endtask

    // Random non-clear key traffic, which must be dropped while busy.
    task automatic noise();
        key_valid = 1'($urandom % 2);
        key_code  = 4'($urandom_range(0, 14));
    endtask

    task automatic m_clear();
        m_phase = P_FIRST;
        m_a = 0; m_b = 0; m_op = 0;
        m_bseen = 0;
        m_res = 0;
    endtask

    task automatic model_key(input logic [3:0] k, output bit started);
        bit dig, opk;
        started = 0;
        dig = (k <= 4'd9);
        opk = (k == 4'hA) || (k == 4'hB);
        if (k == 4'hF) begin
            m_clear();
        end else begin
            case (m_phase)
                P_FIRST:  if (dig) begin m_a = k; m_phase = P_OPWAIT; end
                P_OPWAIT: begin
                    if (dig) m_a = k;
                    else if (opk) begin m_op = k; m_bseen = 0; m_phase = P_SECOND; end
                    else if (k == 4'hE) m_phase = P_ERR;
                end
                P_SECOND: begin
                    if (dig) begin m_b = k; m_bseen = 1; end
                    else if (opk) m_op = k;
                    else if (k == 4'hE) begin
                        if (m_bseen) begin m_phase = P_BUSY; started = 1; end
                        else m_phase = P_ERR;
                    end
                end
                P_SHOW: if (dig) begin m_a = k; m_b = 0; m_op = 0; m_phase = P_OPWAIT; end
                default: ;
            endcase
        end
    endtask

    task automatic press(input logic [3:0] k, input string tag);
        bit started;
        key_valid = 1'b1;
        key_code  = k;
        tick();
        quiet();
        model_key(k, started);
        check_all(tag, started, 1'b0);
    endtask

    // Called in the cycle where complement1_sel is high.
    // mode: 0 normal, 1 conv timeout, 2 exec timeout,
    //       3 clear in conv (with simultaneous finish), 4 clear in exec.
    task automatic run_calc(input int fin_lat, input int done_lat,
                            input logic [7:0] r, input int mode);
        complement1_finish = 1'($urandom % 2);
        noise();
        tick(); quiet();
        if (mode == 1) begin
            check_all("conv_w1", 1'b0, 1'b0);
            for (int i = 2; i <= TO; i++) begin
                noise(); tick(); quiet();
                if (i < TO) check_all("conv_wait", 1'b0, 1'b0);
            end
            m_phase = P_ERR;
            check_all("conv_timeout", 1'b0, 1'b0);
            return;
        end
        check_all("conv_w1", 1'b0, 1'b0);
        for (int i = 1; i < fin_lat; i++) begin
            noise(); tick(); quiet();
            check_all("conv_wait", 1'b0, 1'b0);
        end
        if (mode == 3) begin
            key_valid = 1'b1; key_code = 4'hF; complement1_finish = 1'b1;
            tick(); quiet();
            m_clear();
            check_all("conv_clear", 1'b0, 1'b0);
            complement1_finish = 1'b1;
            tick(); quiet();
            check_all("late_finish", 1'b0, 1'b0);
            return;
        end
        complement1_finish = 1'b1;
        tick(); quiet();
        check_all("alu_start", 1'b0, 1'b1);
        if (mode == 2) begin
            for (int i = 1; i <= TO; i++) begin
                noise(); tick(); quiet();
                if (i < TO) check_all("exec_wait", 1'b0, 1'b0);
            end
            m_phase = P_ERR;
            check_all("exec_timeout", 1'b0, 1'b0);
            return;
        end
        for (int i = 0; i < done_lat; i++) begin
            noise(); tick(); quiet();
            check_all("exec_wait", 1'b0, 1'b0);
        end
        if (mode == 4) begin
            key_valid = 1'b1; key_code = 4'hF;
            tick(); quiet();
            m_clear();
            check_all("exec_clear", 1'b0, 1'b0);
            alu_done = 1'b1; alu_result = r;
            tick(); quiet();
            check_all("late_done", 1'b0, 1'b0);
            return;
        end
        alu_done = 1'b1; alu_result = r;
        tick(); quiet();
        alu_result = 8'($urandom);
        m_res   = r;
        m_phase = P_SHOW;
        check_all("show", 1'b0, 1'b0);
    endtask

    task automatic expect_busy_start();
        if (m_phase != P_BUSY) begin
            n_cmp++;
            n_bad++;
            $error("FAIL start_conv: observed phase %0d expected %0d", m_phase, P_BUSY);
        end
    endtask

    initial begin
        int mode, r;
        logic [3:0] k;

        #12;
        check_all("reset", 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // 3 A 2 E, finish 2 cycles after sel, done 1 cycle after start
        press(4'h3, "t1_k3"); press(4'hA, "t1_kA"); press(4'h2, "t1_k2"); press(4'hE, "t1_kE");
        run_calc(2, 1, 8'h05, 0);
        check("t1_nr", 32'(nr_coded), 32'h32A);
        check("t1_res", 32'(result), 32'h05);
        check("t1_valid", 32'(result_valid), 32'h1);

        // last digit wins, then new digit in SHOW
        press(4'hF, "t2_clr");
        press(4'h7, "t2_k7"); press(4'h4, "t2_k4"); press(4'hB, "t2_kB");
        press(4'h1, "t2_k1"); press(4'h9, "t2_k9"); press(4'hE, "t2_kE");
        check("t2_nr", 32'(nr_coded), 32'h49B);
        run_calc(14, 14, 8'hFE, 0);
        press(4'h6, "t2_k6");
        check("t2_valid", 32'(result_valid), 32'h0);
        check("t2_nr6", 32'(nr_coded), 32'h600);

        // equals with no second operand
        press(4'hF, "t3_clr");
        press(4'h2, "t3_k2"); press(4'hA, "t3_kA"); press(4'hE, "t3_kE");
        check("t3_err", 32'(error), 32'h1);
        press(4'h5, "t3_ignored");
        press(4'hF, "t3_clr2");
        check("t3_err_clr", 32'(error), 32'h0);
        check("t3_nr", 32'(nr_coded), 32'h000);

        // conversion timeout
        press(4'h1, "t4_k1"); press(4'hA, "t4_kA"); press(4'h1, "t4_k1b"); press(4'hE, "t4_kE");
        run_calc(1, 0, 8'h00, 1);
        check("t4_err", 32'(error), 32'h1);
        press(4'hF, "t4_clr");

        // exec timeout
        press(4'h8, "t5_k8"); press(4'hB, "t5_kB"); press(4'h3, "t5_k3"); press(4'hE, "t5_kE");
        run_calc(3, 0, 8'h00, 2);
        press(4'hF, "t5_clr");

        // clear during exec, late done ignored
        press(4'h4, "t6_k4"); press(4'hA, "t6_kA"); press(4'h4, "t6_k4b"); press(4'hE, "t6_kE");
        run_calc(4, 2, 8'h08, 4);
        check("t6_valid", 32'(result_valid), 32'h0);

        // clear with a simultaneous finish during conversion
        press(4'h9, "t7_k9"); press(4'hB, "t7_kB"); press(4'h9, "t7_k9b"); press(4'hE, "t7_kE");
        run_calc(3, 0, 8'h00, 3);

        // reset mid-conversion
        press(4'h1, "t8_k1"); press(4'hA, "t8_kA"); press(4'h2, "t8_k2"); press(4'hE, "t8_kE");
        tick();
        tick();
        rst = 1'b0;
        #1;
        m_clear();
        check_all("t8_rst", 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        tick();
        check_all("t8_post1", 1'b0, 1'b0);
        tick();
        check_all("t8_post2", 1'b0, 1'b0);
        press(4'h5, "t8_k5");
        check("t8_nr", 32'(nr_coded), 32'h500);

        // randomized key traffic against the model
        press(4'hF, "rnd_init");
        for (int it = 0; it < 80; it++) begin
            if ($urandom % 8 == 0) k = 4'hF;
            else k = 4'($urandom_range(0, 14));
            press(k, "rnd_key");
            if (m_phase == P_BUSY) begin
                expect_busy_start();
                r = $urandom % 10;
                if (r < 6) mode = 0;
                else mode = r - 5;
                run_calc($urandom_range(1, 14), $urandom_range(0, 14), 8'($urandom), mode);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
